// File: rtl/lse_reduce_ctrl.sv
// Folds a stream of N log-domain values into one LSE sum by sequencing a shared
// lse_add unit (one element per two cycles, 1-cycle adder latency).
module lse_reduce_ctrl #(
  parameter int WIDTH   = 24,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             add_en,
  output logic [1:0]       add_mode,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             err_timeout
);

  localparam int WT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_NEXT,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] rem_q;
  logic [WT_W-1:0]  wait_q;
  logic             err_q;
  logic             accept;

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_FIRST) || (state_q == S_NEXT);
  assign accept      = in_valid && in_ready;
  assign add_en      = (state_q == S_NEXT) && in_valid;
  assign add_mode    = 2'b00;
  assign add_a       = acc_q;
  assign add_b       = in_data;
  assign out_valid   = (state_q == S_OUTPUT);
  assign out_data    = out_valid ? acc_q : '0;
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q <= count;
            err_q <= 1'b0;
            if (count == '0) begin
              acc_q   <= NEG_INF;
              state_q <= S_OUTPUT;
            end else begin
              state_q <= S_FIRST;
            end
          end
        end
        S_FIRST: begin
          // First element seeds the accumulator directly; no add is issued.
          if (accept) begin
            acc_q   <= in_data;
            rem_q   <= rem_q - CNT_W'(1);
            state_q <= (rem_q == CNT_W'(1)) ? S_OUTPUT : S_NEXT;
          end
        end
        S_NEXT: begin
          if (accept) begin
            rem_q   <= rem_q - CNT_W'(1);
            wait_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A returning result wins over a timeout landing in the same cycle.
          if (add_valid) begin
            acc_q   <= add_result;
            wait_q  <= '0;
            state_q <= (rem_q == '0) ? S_OUTPUT : S_NEXT;
          end else if (wait_q == WT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            wait_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q + WT_W'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lse_reduce_ctrl.sv
// Bench for lse_reduce_ctrl: stub adder (registered a+b), directed and random
// reductions checked against a sum/latency reference model.
module tb_lse_reduce_ctrl;

  localparam logic [23:0] NEG_INF = 24'h800000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  count;
  logic [23:0] in_data;
  logic        busy, in_ready, add_en, out_valid, err_timeout;
  logic [1:0]  add_mode;
  logic [23:0] add_a, add_b, out_data;
  logic [23:0] stub_r;
  logic        stub_v, stub_on;

  int checks = 0;
  int passes = 0;
  int addens, bad, inrdy_cnt, ov_cnt;
  logic [23:0] vals [0:255];

  always #5 clk = ~clk;

  lse_reduce_ctrl #(.WIDTH(24), .CNT_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_en(add_en), .add_mode(add_mode), .add_a(add_a), .add_b(add_b),
    .add_result(stub_r), .add_valid(stub_v),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_timeout(err_timeout)
  );

  always @(posedge clk) begin
    stub_v <= add_en && stub_on && !rst;
    stub_r <= add_a + add_b;
  end

  always @(negedge clk) begin
    if (add_en) addens++;
    if (add_en && !(in_valid && in_ready)) bad++;
    if (in_ready && (!busy || out_valid)) bad++;
    if (in_ready) inrdy_cnt++;
    if (out_valid) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one reduction over vals[0..n-1]; checks result against the plain sum.
  task automatic do_reduce(input int n, input int gap, input int hold, input bit spam);
    logic [23:0] exp_res, first_data;
    int idx, gcnt, cyc, lat, held, accepts;
    bit acc_now, seen, stable, done, rdy_was;
    exp_res = '0;
    for (int i = 0; i < n; i++) exp_res += vals[i];
    if (n == 0) exp_res = NEG_INF;
    addens = 0; bad = 0; inrdy_cnt = 0;
    idx = 0; gcnt = 0; cyc = 0; lat = -1; held = 0; accepts = 0;
    seen = 0; stable = 1; done = 0; first_data = '0;
    start = 1'b1; count = 8'(n);
    in_valid = (n > 0); in_data = (n > 0) ? vals[0] : 24'h0;
    #1; acc_now = in_valid && in_ready;
    while (!done && cyc < 400) begin
      step(); cyc++;
      start = 1'b0;
      rdy_was = out_ready;
      if (cyc == 1) check("err_cleared_on_start", {31'd0, err_timeout}, 32'd0);
      if (acc_now) begin idx++; accepts++; gcnt = gap; end
      if (out_valid) begin
        if (rdy_was) bad++;
        if (!seen) begin seen = 1; lat = cyc; first_data = out_data; end
        else if (out_data !== first_data) stable = 0;
        if (held >= hold) out_ready = 1'b1; else held++;
      end else if (seen) begin
        done = 1;
        out_ready = 1'b0;
        check("idle_after_release", {31'd0, busy}, 32'd0);
      end
      if (!done) begin
        if (idx < n && gcnt == 0) begin in_valid = 1'b1; in_data = vals[idx]; end
        else begin in_valid = 1'b0; in_data = 24'h0; end
        if (gcnt > 0) gcnt--;
        if (spam && busy && !out_valid) begin start = 1'b1; count = 8'($urandom_range(1, 9)); end
      end
      #1; acc_now = in_valid && in_ready;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b0; in_data = 24'h0;
    check("completed", {31'd0, done}, 32'd1);
    check("result", {8'd0, first_data}, {8'd0, exp_res});
    check("accepted_elems", accepts, n);
    check("add_en_pulses", addens, (n > 0) ? n - 1 : 0);
    check("out_stable", {31'd0, stable}, 32'd1);
    check("protocol_violations", bad, 0);
    if (n == 0) check("no_in_ready_cnt0", inrdy_cnt, 0);
    if (gap == 0) check("latency", lat, (n == 0) ? 1 : 2 * n);
  endtask

  initial begin
    int edges, n;
    rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; stub_on = 1'b1;
    step(); step(); step();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_add_en", {31'd0, add_en}, 0);
    check("rst_add_mode", {30'd0, add_mode}, 0);
    check("rst_add_a", {8'd0, add_a}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {8'd0, out_data}, 0);
    check("rst_err", {31'd0, err_timeout}, 0);
    rst = 1'b0;
    step();

    vals[0] = 24'd1; vals[1] = 24'd2; vals[2] = 24'd3; vals[3] = 24'd4;
    do_reduce(4, 0, 0, 0);
    vals[0] = 24'h000123;
    do_reduce(1, 0, 0, 0);
    do_reduce(0, 0, 0, 0);
    vals[0] = 24'd1; vals[1] = 24'd2; vals[2] = 24'd3;
    do_reduce(3, 3, 0, 1);
    vals[0] = 24'h00abcd; vals[1] = 24'h001111;
    do_reduce(2, 0, 5, 0);

    // Adder never answers: expect 15 WAIT cycles then abort with the error flag.
    stub_on = 1'b0; ov_cnt = 0;
    start = 1'b1; count = 8'd2;
    step(); start = 1'b0; in_valid = 1'b1; in_data = 24'd5;
    step(); in_data = 24'd7; #1;
    check("to_add_en", {31'd0, add_en}, 1);
    step(); in_valid = 1'b0; in_data = 24'h0;
    edges = 1;
    while (!err_timeout && edges < 40) begin step(); edges++; end
    check("to_wait_cycles", edges - 1, 15);
    check("to_err", {31'd0, err_timeout}, 1);
    check("to_idle", {31'd0, busy}, 0);
    check("to_no_output", ov_cnt, 0);
    stub_on = 1'b1;
    vals[0] = 24'd9; vals[1] = 24'd6;
    do_reduce(2, 0, 0, 0);

    // Reset while waiting on the adder.
    start = 1'b1; count = 8'd3;
    step(); start = 1'b0; in_valid = 1'b1; in_data = 24'd2;
    step(); in_data = 24'd3; #1;
    check("rw_add_en", {31'd0, add_en}, 1);
    step(); in_valid = 1'b0; in_data = 24'h0; rst = 1'b1;
    step();
    check("rw_busy", {31'd0, busy}, 0);
    check("rw_in_ready", {31'd0, in_ready}, 0);
    check("rw_add_en0", {31'd0, add_en}, 0);
    check("rw_add_a", {8'd0, add_a}, 0);
    check("rw_out_valid", {31'd0, out_valid}, 0);
    check("rw_out_data", {8'd0, out_data}, 0);
    rst = 1'b0;
    step();
    vals[0] = 24'd10; vals[1] = 24'd20; vals[2] = 24'd30;
    do_reduce(3, 0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) vals[i] = 24'($urandom);
      do_reduce(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
